// File: rtl/reg_bank_ld_pkg.sv
// reg_bank_ld_pkg: op encodings shared by the register bank and its cells
package reg_bank_ld_pkg;
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_SHL  = 2'b10,
    OP_SHR  = 2'b11
  } op_e;
endpackage

// File: rtl/reg_bank_ld_if.sv
// reg_bank_ld_if: write/modify port plus two read ports of the register bank
interface reg_bank_ld_if
  import reg_bank_ld_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             clr;
  op_e              op;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] qa;
  logic [WIDTH-1:0] qb;
  logic             sout;
  modport master (output clr, op, waddr, d, sin, raddr_a, raddr_b, input qa, qb, sout);
  modport slave  (input clr, op, waddr, d, sin, raddr_a, raddr_b, output qa, qb, sout);
endinterface

// File: rtl/reg_cell.sv
// reg_cell: one WIDTH-bit load/shift register entry
module reg_cell
  import reg_bank_ld_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  op_e              op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout
);
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_nxt;
  always_comb begin
    w_nxt = op == OP_LOAD ? d :
            op == OP_SHL  ? {r_q[WIDTH-2:0], sin} :
            op == OP_SHR  ? {sin, r_q[WIDTH-1:1]} : r_q;
    sout  = op == OP_SHL ? r_q[WIDTH-1] : op == OP_SHR ? r_q[0] : 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= RST_VAL;
    else if (clr) r_q <= RST_VAL;
    else if (en) r_q <= w_nxt;
  assign q = r_q;
endmodule

// File: rtl/reg_bank_ld.sv
// reg_bank_ld: 2**AW load/shift registers, one modify port, two comb read ports
module reg_bank_ld
  import reg_bank_ld_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               AW      = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               BYPASS  = 1'b0
) (
  input logic          clk,
  input logic          rst,
  reg_bank_ld_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  logic [WIDTH-1:0] w_q [DEPTH];
  logic [DEPTH-1:0] w_en;
  logic [DEPTH-1:0] w_sout;
  logic             w_ld;
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    assign w_en[i] = bus.waddr == AW'(i);
    reg_cell #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_cell (
      .clk (clk),
      .rst (rst),
      .clr (bus.clr),
      .en  (w_en[i]),
      .op  (bus.op),
      .d   (bus.d),
      .sin (bus.sin),
      .q   (w_q[i]),
      .sout(w_sout[i])
    );
  end
  // bypass only when the LOAD will actually land at the next edge
  assign w_ld     = BYPASS && bus.op == OP_LOAD && !rst && !bus.clr;
  assign bus.qa   = w_ld && bus.raddr_a == bus.waddr ? bus.d : w_q[bus.raddr_a];
  assign bus.qb   = w_ld && bus.raddr_b == bus.waddr ? bus.d : w_q[bus.raddr_b];
  assign bus.sout = w_sout[bus.waddr];
endmodule
